// File: rtl/dec_gray2bin_chk_if.sv
// ---------------------------------------------------------------------------
// dec_gray2bin_chk_if
//
// Purpose:
//   Bundles the two valid/ready streams of the gray-to-binary decoder.
//   The input stream carries gray-coded words and the output stream carries
//   decoded binary words with their step-error flag.
//
// Signals:
//   in_valid   gray word present on the input stream
//   in_ready   decoder can accept a gray word this cycle
//   gray       gray-coded input word, WIDTH bits
//   out_valid  bin/step_err hold a valid result
//   out_ready  downstream accepts the result this cycle
//   bin        decoded binary word, WIDTH bits
//   step_err   result's gray word differed from the previous accepted word
//              in more than one bit
//
// Modports:
//   master  the environment: drives the input stream and consumes the output
//   slave   the decoder
// ---------------------------------------------------------------------------
interface dec_gray2bin_chk_if #(
    parameter int WIDTH = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin;
    logic             step_err;

    modport master (
        output in_valid,
        output gray,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin,
        input  step_err
    );

    modport slave (
        input  in_valid,
        input  gray,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin,
        output step_err
    );
endinterface

// File: rtl/dec_gray2bin_chk.sv
// ---------------------------------------------------------------------------
// dec_gray2bin_chk
//
// Purpose:
//   Receive-side consumer of gray-coded pointer/counter words. Each accepted
//   gray word is decoded to binary and held in a one-entry output register
//   that is exposed on a valid/ready stream. Throughput is one word per cycle;
//   a word accepted on edge N is visible on bin with out_valid=1 after edge N.
//
//   Optional step checker (macro GRAY_STEP_CHK_EN): compares each accepted
//   word with the previously accepted one and flags the result when they
//   differ in more than one bit. Flagged results bump a saturating counter.
//   Without the macro, step_err and err_cnt are constant 0 and err_clr is
//   ignored; decode and handshake behave identically.
//
// Parameters:
//   WIDTH      data width of gray in / bin out (>= 2)
//   ERR_CNT_W  width of the saturating step-error counter (>= 1)
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst        synchronous active-high reset
//   bus        stream interface (slave modport): in_valid/in_ready/gray in,
//              out_valid/out_ready/bin/step_err out
//   err_clr    synchronous clear of err_cnt (takes priority over increment)
//   err_cnt    saturating count of step errors
// ---------------------------------------------------------------------------
module dec_gray2bin_chk #(
    parameter int WIDTH     = 10,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dec_gray2bin_chk_if.slave    bus,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // -----------------------------------------------------------------------
    // Output register state
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic             step_err_q;
    logic             step_err_d;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] dec_bin;
    logic             step_err_next;

    // The register can take a new word when it is empty or when its current
    // word leaves this same cycle, which gives back-to-back throughput.
    assign in_ready = (state_q == ST_EMPTY) | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;

    // -----------------------------------------------------------------------
    // Gray to binary decode
    // bin[i] is the XOR of all gray bits from i up to the MSB. Writing each
    // bit as an independent reduction keeps the net free of a bit-to-bit
    // dependency chain through the vector.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign dec_bin[gi] = ^bus.gray[WIDTH-1:gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Output register next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        step_err_d = step_err_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // out_ready with a new accept keeps the register full and
                // reloads it; without out_ready accept is impossible and the
                // held word stays stable.
                if (bus.out_ready && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (accept) begin
            bin_d      = dec_bin;
            step_err_d = step_err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            bin_q      <= '0;
            step_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            step_err_q <= step_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.bin       = bin_q;
    assign bus.step_err  = step_err_q;

`ifdef GRAY_STEP_CHK_EN
    // -----------------------------------------------------------------------
    // Step checker
    // -----------------------------------------------------------------------
    localparam logic [WIDTH-1:0]     GRAY_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

    logic [WIDTH-1:0]     prev_gray_q;
    logic [WIDTH-1:0]     prev_gray_d;
    logic                 prev_vld_q;
    logic                 prev_vld_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    logic [WIDTH-1:0]     gray_diff;
    logic                 multi_bit;

    // More than one differing bit is the same as "diff still non-zero after
    // clearing its lowest set bit", so no full popcount is needed.
    assign gray_diff     = bus.gray ^ prev_gray_q;
    assign multi_bit     = |(gray_diff & (gray_diff - GRAY_ONE));
    assign step_err_next = prev_vld_q & multi_bit;

    always_comb begin
        prev_gray_d = prev_gray_q;
        prev_vld_d  = prev_vld_q;
        err_cnt_d   = err_cnt_q;

        if (accept) begin
            prev_gray_d = bus.gray;
            prev_vld_d  = 1'b1;
            if (step_err_next && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end

        // Clear wins over a same-cycle increment; the history is untouched so
        // the next word is still compared against the last accepted one.
        if (err_clr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray_q <= '0;
            prev_vld_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            prev_gray_q <= prev_gray_d;
            prev_vld_q  <= prev_vld_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    // Checker not built: results are never flagged and the counter reads 0.
    logic unused_err_clr;

    assign step_err_next  = 1'b0;
    assign err_cnt        = '0;
    assign unused_err_clr = err_clr;
`endif

endmodule
